lock_controller: RTL and testbench

LOCK_CONTROLLER -- requirements
Module: lock_controller

---
 rtl/lock_controller.sv | 166 ++++++++++++++++
 tb/tb_lock_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lock_controller.sv
// Combination lock controller. Four push-buttons each enter one 2-bit digit.
// A full code is compared against the stored code. A match unlocks, and while
// unlocked the code can be changed. Repeated failures can force a timed lockout.
// Optional feature: define LOCK_CONTROLLER_LOCKOUT_EN to enable the
// failure counter and the LOCKOUT state. With the macro undefined, a
// mismatch always returns to LOCKED and lockedOut stays low.
module lock_controller #(
    parameter int                         CODE_LENGTH    = 4,
    parameter logic [2*CODE_LENGTH-1:0]   DEFAULT_CODE   = 8'b00_01_10_11,
    parameter int                         MAX_ATTEMPTS   = 3,
    parameter int                         LOCKOUT_CYCLES = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] buttonPresses,
    output logic       unlocked,
    output logic       error,
    output logic       lockedOut,
    output logic [3:0] digitCount
);

    localparam int CW = 2 * CODE_LENGTH;

    localparam logic [2:0] LOCKED   = 3'd0;
    localparam logic [2:0] CHECK    = 3'd1;
    localparam logic [2:0] UNLOCKED = 3'd2;
    localparam logic [2:0] SET_CODE = 3'd3;
    localparam logic [2:0] LOCKOUT  = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] entry;
    logic [CW-1:0] storedCode;
    logic [CW-1:0] shifted;
    logic [1:0]    pressDigit;
    logic          validPress;
    logic          lastDigit;
    logic          codeMatch;
    logic          lockoutTrip;
    logic          lockoutDone;

    // Decode the pressed button into a digit; only one-hot cycles count as presses
    always_comb begin
        pressDigit = 2'd0;
        case (buttonPresses)
            4'b0010: pressDigit = 2'd1;
            4'b0100: pressDigit = 2'd2;
            4'b1000: pressDigit = 2'd3;
            default: pressDigit = 2'd0;
        endcase
    end

    assign validPress = $onehot(buttonPresses);
    assign shifted    = {entry[CW-3:0], pressDigit};
    assign lastDigit  = (digitCount == 4'(CODE_LENGTH - 1));
    assign codeMatch  = (entry == storedCode);

`ifdef LOCK_CONTROLLER_LOCKOUT_EN
    localparam int FW = $clog2(MAX_ATTEMPTS + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

    logic [FW-1:0] failCount;
    logic [LW-1:0] lockoutCount;

    assign lockoutTrip = (state == CHECK) && !codeMatch &&
                         (failCount == FW'(MAX_ATTEMPTS - 1));
    assign lockoutDone = (lockoutCount == LW'(LOCKOUT_CYCLES - 1));

    // Track consecutive failures and time the lockout period
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            failCount    <= '0;
            lockoutCount <= '0;
        end else begin
            if (state == CHECK) begin
                if (codeMatch) begin
                    failCount <= '0;
                end else begin
                    failCount <= failCount + 1'b1;
                end
            end else if (state == LOCKOUT) begin
                if (lockoutDone) begin
                    lockoutCount <= '0;
                    failCount    <= '0;
                end else begin
                    lockoutCount <= lockoutCount + 1'b1;
                end
            end
        end
    end

    assign lockedOut = (state == LOCKOUT);
`else
    assign lockoutTrip = 1'b0;
    assign lockoutDone = 1'b1;
    assign lockedOut   = 1'b0;
`endif

    // Main lock state machine: digit capture, code check, unlock and code change
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= LOCKED;
            entry      <= '0;
            storedCode <= DEFAULT_CODE;
            digitCount <= 4'd0;
        end else begin
            case (state)
                LOCKED: begin
                    if (validPress) begin
                        entry      <= shifted;
                        digitCount <= digitCount + 4'd1;
                        if (lastDigit) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    entry      <= '0;
                    digitCount <= 4'd0;
                    if (codeMatch) begin
                        state <= UNLOCKED;
                    end else if (lockoutTrip) begin
                        state <= LOCKOUT;
                    end else begin
                        state <= LOCKED;
                    end
                end
                UNLOCKED: begin
                    if (buttonPresses == 4'b0001) begin
                        state      <= LOCKED;
                        entry      <= '0;
                        digitCount <= 4'd0;
                    end else if (buttonPresses == 4'b1000) begin
                        state      <= SET_CODE;
                        entry      <= '0;
                        digitCount <= 4'd0;
                    end
                end
                SET_CODE: begin
                    if (validPress) begin
                        if (lastDigit) begin
                            storedCode <= shifted;
                            entry      <= '0;
                            digitCount <= 4'd0;
                            state      <= UNLOCKED;
                        end else begin
                            entry      <= shifted;
                            digitCount <= digitCount + 4'd1;
                        end
                    end
                end
                LOCKOUT: begin
                    if (lockoutDone) begin
                        state <= LOCKED;
                    end
                end
                default: begin
                    state <= LOCKED;
                end
            endcase
        end
    end

    assign unlocked = (state == UNLOCKED) || (state == SET_CODE);
    assign error    = (state == CHECK) && !codeMatch;

endmodule

// File: tb/tb_lock_controller.sv
// Directed self-checking bench for lock_controller (CODE_LENGTH 4, LOCKOUT_CYCLES 20).
// Expectations follow LOCK_CONTROLLER_LOCKOUT_EN when it is defined for the build.
module tb_lock_controller;

    logic       clock;
    logic       reset;
    logic [3:0] buttonPresses;
    logic       unlocked;
    logic       error;
    logic       lockedOut;
    logic [3:0] digitCount;

    int checkCount = 0;
    int failCount  = 0;

`ifdef LOCK_CONTROLLER_LOCKOUT_EN
    localparam int EXP_LOCKOUT = 20;
`else
    localparam int EXP_LOCKOUT = 0;
`endif

    lock_controller #(
        .CODE_LENGTH   (4),
        .DEFAULT_CODE  (8'b00_01_10_11),
        .MAX_ATTEMPTS  (3),
        .LOCKOUT_CYCLES(20)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .buttonPresses(buttonPresses),
        .unlocked     (unlocked),
        .error        (error),
        .lockedOut    (lockedOut),
        .digitCount   (digitCount)
    );

    // Free-running 100 MHz clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Drive one pattern for a single cycle; returns at the negedge after the capturing edge
    task automatic applyStimulus(input logic [3:0] pattern);
        @(negedge clock);
        buttonPresses = pattern;
        @(negedge clock);
        buttonPresses = 4'b0000;
    endtask

    task automatic pressDigit(input int d);
        applyStimulus(4'b0001 << d);
    endtask

    task automatic enterCode(input int d0, input int d1, input int d2, input int d3);
        pressDigit(d0);
        pressDigit(d1);
        pressDigit(d2);
        pressDigit(d3);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Count lockout cycles while hammering buttons; every press must be ignored
    task automatic measureLockout(input string tag);
        int cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!lockedOut) break;
            cycles++;
            checkOutput({tag, "_dc"}, digitCount, 0);
            checkOutput({tag, "_unl"}, unlocked, 0);
            buttonPresses = 4'b0001 << (i % 4);
        end
        buttonPresses = 4'b0000;
        checkOutput({tag, "_len"}, cycles, EXP_LOCKOUT);
    endtask

    task automatic threeWrong();
        for (int k = 0; k < 3; k++) begin
            enterCode(3, 2, 1, 0);
            checkOutput("wrong_err", error, 1);
        end
    endtask

    initial begin
        reset         = 1'b1;
        buttonPresses = 4'b0000;
        idle(2);
        checkOutput("rst_unl", unlocked, 0);
        checkOutput("rst_err", error, 0);
        checkOutput("rst_lo", lockedOut, 0);
        checkOutput("rst_dc", digitCount, 0);
        reset = 1'b0;

        // Default code unlocks two cycles after the last press
        pressDigit(0); checkOutput("p1_dc", digitCount, 1);
        pressDigit(1); checkOutput("p2_dc", digitCount, 2);
        pressDigit(2); checkOutput("p3_dc", digitCount, 3);
        pressDigit(3); checkOutput("p4_dc", digitCount, 4);
        checkOutput("chk_err", error, 0);
        checkOutput("chk_unl", unlocked, 0);
        idle(1);
        checkOutput("open_unl", unlocked, 1);
        checkOutput("open_dc", digitCount, 0);
        checkOutput("open_err", error, 0);
        pressDigit(0);
        checkOutput("relock_unl", unlocked, 0);

        // Wrong code pulses error for exactly the check cycle
        enterCode(3, 2, 1, 0);
        checkOutput("bad_err", error, 1);
        checkOutput("bad_unl", unlocked, 0);
        idle(1);
        checkOutput("bad_err_gone", error, 0);
        checkOutput("bad_dc", digitCount, 0);
        checkOutput("bad_unl2", unlocked, 0);

        // Multi-bit and empty cycles are ignored during entry
        pressDigit(0);
        applyStimulus(4'b0011);
        checkOutput("multi_dc", digitCount, 1);
        applyStimulus(4'b0000);
        checkOutput("zero_dc", digitCount, 1);
        pressDigit(1);
        pressDigit(2);
        pressDigit(3);
        checkOutput("multi_err", error, 0);
        idle(1);
        checkOutput("multi_unl", unlocked, 1);

        // Change code to 2,2,1,1 then verify new and old codes
        pressDigit(1);
        checkOutput("b1_ignored", unlocked, 1);
        pressDigit(3);
        checkOutput("set_unl", unlocked, 1);
        checkOutput("set_dc", digitCount, 0);
        pressDigit(2); checkOutput("set_dc1", digitCount, 1);
        pressDigit(2);
        pressDigit(1); checkOutput("set_dc3", digitCount, 3);
        pressDigit(1);
        checkOutput("set_done_unl", unlocked, 1);
        pressDigit(0);
        checkOutput("set_lock", unlocked, 0);
        enterCode(2, 2, 1, 1);
        checkOutput("new_err", error, 0);
        idle(1);
        checkOutput("new_unl", unlocked, 1);
        pressDigit(0);
        enterCode(0, 1, 2, 3);
        checkOutput("old_err", error, 1);
        idle(1);
        checkOutput("old_unl", unlocked, 0);

        // Reset in the middle of entry restores the default code
        pressDigit(0);
        pressDigit(1);
        checkOutput("mid_dc", digitCount, 2);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_dc", digitCount, 0);
        checkOutput("arst_unl", unlocked, 0);
        checkOutput("arst_err", error, 0);
        checkOutput("arst_lo", lockedOut, 0);
        @(negedge clock);
        reset = 1'b0;
        enterCode(0, 1, 2, 3);
        checkOutput("dflt_err", error, 0);
        idle(1);
        checkOutput("dflt_unl", unlocked, 1);
        pressDigit(0);

        // Three wrong codes trigger lockout when enabled; correct code works afterwards
        threeWrong();
        measureLockout("lockA");
        enterCode(0, 1, 2, 3);
        checkOutput("post_lo_err", error, 0);
        idle(1);
        checkOutput("post_lo_unl", unlocked, 1);
        pressDigit(0);

        // Reset during lockout clears everything at once
        threeWrong();
        idle(5);
        checkOutput("lockB_lo", lockedOut, (EXP_LOCKOUT > 0) ? 1 : 0);
        #2 reset = 1'b1;
        #1;
        checkOutput("lockB_rst_lo", lockedOut, 0);
        checkOutput("lockB_rst_unl", unlocked, 0);
        checkOutput("lockB_rst_dc", digitCount, 0);
        @(negedge clock);
        reset = 1'b0;
        enterCode(0, 1, 2, 3);
        checkOutput("lockB_err", error, 0);
        idle(1);
        checkOutput("lockB_unl", unlocked, 1);
        checkOutput("lockB_lo2", lockedOut, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
